fabm_acc_out_stage: RTL and testbench

- Downstream consumer of the FABM 32x32 final carry-chain adder.
- Assembles the carry-chain sum bits [41:4] with the separately produced low bits [3:0] into one signed product.
- Accumulates PROD_PER_OUT consecutive products and presents one registered result on a valid/ready output.
- Registers the adder output and decouples multiplier throughput from the consumer.

---
 rtl/fabm_pkg.sv | 15 +
 rtl/fabm_acc_out_stage_if.sv | 25 ++
 rtl/fabm_acc_add.sv | 27 ++
 rtl/fabm_acc_out_stage.sv | 109 ++++++++++
 tb/tb_fabm_acc_out_stage.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fabm_pkg.sv
// Shared types and helpers for the FABM accumulator output stage.
package fabm_pkg;

    localparam int FABM_PROD_W = 42;
    localparam int FABM_ACC_W  = 48;
    localparam int FABM_SEXT_W = 64;

    typedef enum logic {ST_ACC, ST_OUT} state_t;

    // Sign-extends the assembled product to the widest supported accumulator.
    function automatic logic signed [FABM_SEXT_W-1:0] sext_prod(input logic [FABM_PROD_W-1:0] p);
        return FABM_SEXT_W'($signed(p));
    endfunction

endpackage

// File: rtl/fabm_acc_out_stage_if.sv
// Product-in / result-out handshake bundle of the FABM accumulator output stage.
interface fabm_acc_out_stage_if #(
    parameter int PROD_W = 42,
    parameter int ACC_W  = 48
);
    logic [PROD_W-5:0]        prod_hi;
    logic [3:0]               prod_lo;
    logic                     in_valid;
    logic                     in_ready;
    logic                     acc_clr;
    logic signed [ACC_W-1:0]  res;
    logic                     out_valid;
    logic                     out_ready;
    logic                     ovf;

    modport master (
        output prod_hi, prod_lo, in_valid, acc_clr, out_ready,
        input  in_ready, res, out_valid, ovf
    );

    modport slave (
        input  prod_hi, prod_lo, in_valid, acc_clr, out_ready,
        output in_ready, res, out_valid, ovf
    );
endinterface

// File: rtl/fabm_acc_add.sv
// Signed accumulator adder with overflow detect; FABM_ACC_SAT_EN selects clamping
// instead of two's-complement wrap on overflow.
module fabm_acc_add #(
    parameter int W = 48
) (
    input  logic signed [W-1:0] a_i,
    input  logic signed [W-1:0] b_i,
    output logic signed [W-1:0] sum_o,
    output logic                ovf_o
);
    logic signed [W-1:0] sum_raw;

    assign sum_raw = a_i + b_i;
    assign ovf_o   = (a_i[W-1] == b_i[W-1]) && (sum_raw[W-1] != a_i[W-1]);

`ifdef FABM_ACC_SAT_EN
    // Both operands share a sign on overflow, so a_i's sign picks the rail.
    function automatic logic signed [W-1:0] sat_rail(input logic neg);
        return neg ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    endfunction

    assign sum_o = ovf_o ? sat_rail(a_i[W-1]) : sum_raw;
`else
    assign sum_o = sum_raw;
`endif

endmodule

// File: rtl/fabm_acc_out_stage.sv
// Assembles FABM products, sums PROD_PER_OUT of them and hands the result out on
// a valid/ready port. Optional saturation via FABM_ACC_SAT_EN (see fabm_acc_add).
module fabm_acc_out_stage
    import fabm_pkg::*;
#(
    parameter int PROD_W       = FABM_PROD_W,
    parameter int ACC_W        = FABM_ACC_W,
    parameter int PROD_PER_OUT = 4,
    parameter int CNT_W        = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    fabm_acc_out_stage_if.slave  bus
);
    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] res_q, res_d;
    logic                    out_valid_q, out_valid_d;
    logic                    ovf_q, ovf_d;

    logic [PROD_W-1:0]       prod_raw;
    logic signed [ACC_W-1:0] prod;
    logic signed [ACC_W-1:0] add_a, add_sum;
    logic                    add_ovf;
    logic                    in_ready, accept, cnt_zero, cnt_last;

    assign prod_raw = {bus.prod_hi, bus.prod_lo};
    assign prod     = ACC_W'(sext_prod(prod_raw));

    assign cnt_zero = (cnt_q == '0);
    assign cnt_last = (cnt_q == CNT_W'(PROD_PER_OUT - 1));

    // cnt is zero in ST_OUT, so a handoff accept starts the new group from zero.
    assign add_a = cnt_zero ? '0 : acc_q;

    fabm_acc_add #(.W(ACC_W)) u_add (
        .a_i   (add_a),
        .b_i   (prod),
        .sum_o (add_sum),
        .ovf_o (add_ovf)
    );

    always_comb begin
        in_ready = 1'b0;
        if (!bus.acc_clr) begin
            in_ready = (state_q == ST_ACC) ? 1'b1 : bus.out_ready;
        end
    end

    assign accept = bus.in_valid & in_ready;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        res_d       = res_q;
        out_valid_d = out_valid_q;
        ovf_d       = ovf_q;

        if (bus.acc_clr) begin
            state_d     = ST_ACC;
            cnt_d       = '0;
            acc_d       = '0;
            out_valid_d = 1'b0;
            ovf_d       = 1'b0;
        end else if (accept) begin
            ovf_d = cnt_zero ? add_ovf : (ovf_q | add_ovf);
            if (cnt_last) begin
                res_d       = add_sum;
                out_valid_d = 1'b1;
                cnt_d       = '0;
                state_d     = ST_OUT;
            end else begin
                acc_d       = add_sum;
                cnt_d       = cnt_q + 1'b1;
                out_valid_d = 1'b0;
                state_d     = ST_ACC;
            end
        end else if (state_q == ST_OUT && bus.out_ready) begin
            out_valid_d = 1'b0;
            state_d     = ST_ACC;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_ACC;
            cnt_q       <= '0;
            acc_q       <= '0;
            res_q       <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            res_q       <= res_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.res       = res_q;
    assign bus.out_valid = out_valid_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_fabm_acc_out_stage.sv
// Bench for fabm_acc_out_stage: three instances (default, ACC_W=43, PROD_PER_OUT=1).
module tb_fabm_acc_out_stage;
    import fabm_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

`ifdef FABM_ACC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    fabm_acc_out_stage_if #(.PROD_W(42), .ACC_W(48)) if0 ();
    fabm_acc_out_stage_if #(.PROD_W(42), .ACC_W(43)) if1 ();
    fabm_acc_out_stage_if #(.PROD_W(42), .ACC_W(48)) if2 ();

    fabm_acc_out_stage #(.PROD_W(42), .ACC_W(48), .PROD_PER_OUT(4), .CNT_W(8)) u0 (
        .clk(clk), .rst(rst), .bus(if0));
    fabm_acc_out_stage #(.PROD_W(42), .ACC_W(43), .PROD_PER_OUT(4), .CNT_W(8)) u1 (
        .clk(clk), .rst(rst), .bus(if1));
    fabm_acc_out_stage #(.PROD_W(42), .ACC_W(48), .PROD_PER_OUT(1), .CNT_W(8)) u2 (
        .clk(clk), .rst(rst), .bus(if2));

    int n_checks = 0;
    int n_fail   = 0;

    // Group sum in true integer arithmetic, then wrapped or clamped into a w-bit range.
    function automatic void model_group(input longint prods[$], input int w, input bit sat,
                                        output longint res, output bit ovf);
        longint mx, mn, acc, s;
        mx  = (longint'(1) <<< (w - 1)) - 1;
        mn  = -(longint'(1) <<< (w - 1));
        acc = 0;
        ovf = 1'b0;
        foreach (prods[i]) begin
            s = acc + prods[i];
            if (s > mx || s < mn) begin
                ovf = 1'b1;
                if (sat) acc = (s > mx) ? mx : mn;
                else     acc = (s > mx) ? s - (longint'(1) <<< w) : s + (longint'(1) <<< w);
            end else begin
                acc = s;
            end
        end
        res = acc;
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input longint p);
        if0.prod_hi = p[41:4];
        if0.prod_lo = p[3:0];
    endtask

    task automatic drive1(input longint p);
        if1.prod_hi = p[41:4];
        if1.prod_lo = p[3:0];
    endtask

    task automatic feed0(input longint p);
        drive0(p);
        if0.in_valid = 1'b1;
        cycle();
        if0.in_valid = 1'b0;
    endtask

    task automatic feed1(input longint p);
        drive1(p);
        if1.in_valid = 1'b1;
        cycle();
        if1.in_valid = 1'b0;
    endtask

    task automatic idle_all();
        if0.in_valid = 1'b0; if0.acc_clr = 1'b0; if0.out_ready = 1'b1; drive0(0);
        if1.in_valid = 1'b0; if1.acc_clr = 1'b0; if1.out_ready = 1'b1; drive1(0);
        if2.in_valid = 1'b0; if2.acc_clr = 1'b0; if2.out_ready = 1'b1;
        if2.prod_hi = '0; if2.prod_lo = '0;
    endtask

    task automatic test_reset();
        longint q[$];
        longint er;
        bit eo;
        idle_all();
        rst = 1'b1;
        if0.in_valid = 1'b1; drive0(123);
        repeat (2) cycle();
        n_checks++; if (if0.res !== 48'h0 || if0.out_valid !== 1'b0 || if0.ovf !== 1'b0) begin
            n_fail++; $display("FAIL reset_u0: res=%0h ov=%b ovf=%b, want 0/0/0", if0.res, if0.out_valid, if0.ovf); end
        n_checks++; if (if1.res !== 43'h0 || if1.out_valid !== 1'b0 || if1.ovf !== 1'b0) begin
            n_fail++; $display("FAIL reset_u1: res=%0h ov=%b ovf=%b, want 0/0/0", if1.res, if1.out_valid, if1.ovf); end
        n_checks++; if (if2.res !== 48'h0 || if2.out_valid !== 1'b0 || if2.ovf !== 1'b0) begin
            n_fail++; $display("FAIL reset_u2: res=%0h ov=%b ovf=%b, want 0/0/0", if2.res, if2.out_valid, if2.ovf); end
        rst = 1'b0;
        if0.in_valid = 1'b0;
        #1;
        n_checks++; if (if0.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready: got %b want 1", if0.in_ready); end
        // Reset mid-group must discard the partial count and sum.
        feed0(5); feed0(6);
        rst = 1'b1; if0.in_valid = 1'b1; drive0(7);
        cycle();
        rst = 1'b0; if0.in_valid = 1'b0;
        q = {1, 1, 1, 1};
        model_group(q, 48, SAT, er, eo);
        foreach (q[i]) feed0(q[i]);
        n_checks++; if (if0.out_valid !== 1'b1 || if0.res !== er[47:0]) begin
            n_fail++; $display("FAIL reset_midgroup: res=%0h ov=%b, want %0h/1", if0.res, if0.out_valid, er[47:0]); end
        cycle();
    endtask

    task automatic test_basic();
        longint q[$];
        longint er;
        bit eo;
        q = {5, 7, -3, 1};
        model_group(q, 48, SAT, er, eo);
        for (int i = 0; i < 3; i++) feed0(q[i]);
        n_checks++; if (if0.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL basic_early_valid: got %b want 0", if0.out_valid); end
        feed0(q[3]);
        n_checks++; if (if0.out_valid !== 1'b1 || if0.res !== er[47:0] || if0.ovf !== eo) begin
            n_fail++; $display("FAIL basic_res: res=%0h ov=%b ovf=%b, want %0h/1/%b", if0.res, if0.out_valid, if0.ovf, er[47:0], eo); end
        cycle();
        n_checks++; if (if0.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL basic_one_cycle: out_valid=%b want 0", if0.out_valid); end
    endtask

    task automatic test_negative();
        repeat (4) begin
            if0.prod_hi = 38'h3F_FFFF_FFFF; if0.prod_lo = 4'hE; if0.in_valid = 1'b1;
            cycle();
        end
        if0.in_valid = 1'b0;
        n_checks++; if (if0.out_valid !== 1'b1 || if0.res !== 48'hFFFF_FFFF_FFF8 || if0.ovf !== 1'b0) begin
            n_fail++; $display("FAIL negative_res: res=%0h ov=%b ovf=%b, want fffffffffff8/1/0", if0.res, if0.out_valid, if0.ovf); end
        cycle();
    endtask

    task automatic test_backpressure();
        longint q[$];
        longint er;
        bit eo;
        q = {1, 2, 3, 4};
        foreach (q[i]) feed0(q[i]);
        if0.out_ready = 1'b0; if0.in_valid = 1'b1; drive0(9);
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++; if (if0.in_ready !== 1'b0) begin
                n_fail++; $display("FAIL bp_in_ready: cycle %0d got %b want 0", i, if0.in_ready); end
            cycle();
            n_checks++; if (if0.out_valid !== 1'b1 || if0.res !== 48'd10) begin
                n_fail++; $display("FAIL bp_hold: cycle %0d res=%0h ov=%b, want a/1", i, if0.res, if0.out_valid); end
        end
        if0.out_ready = 1'b1;
        #1;
        n_checks++; if (if0.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_handoff_ready: got %b want 1", if0.in_ready); end
        cycle();
        if0.in_valid = 1'b0;
        n_checks++; if (if0.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL bp_handoff_valid: got %b want 0", if0.out_valid); end
        q = {9, 1, 1, 1};
        model_group(q, 48, SAT, er, eo);
        feed0(1); feed0(1);
        n_checks++; if (if0.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL bp_group_early: got %b want 0", if0.out_valid); end
        feed0(1);
        n_checks++; if (if0.out_valid !== 1'b1 || if0.res !== er[47:0]) begin
            n_fail++; $display("FAIL bp_new_group: res=%0h ov=%b, want %0h/1", if0.res, if0.out_valid, er[47:0]); end
        cycle();
    endtask

    task automatic test_clr();
        feed0(100); feed0(200);
        if0.acc_clr = 1'b1; if0.in_valid = 1'b1; drive0(50);
        #1;
        n_checks++; if (if0.in_ready !== 1'b0) begin
            n_fail++; $display("FAIL clr_in_ready: got %b want 0", if0.in_ready); end
        cycle();
        if0.acc_clr = 1'b0; if0.in_valid = 1'b0;
        repeat (4) feed0(1);
        n_checks++; if (if0.out_valid !== 1'b1 || if0.res !== 48'd4) begin
            n_fail++; $display("FAIL clr_partial: res=%0h ov=%b, want 4/1", if0.res, if0.out_valid); end
        if0.acc_clr = 1'b1; if0.out_ready = 1'b1; if0.in_valid = 1'b1; drive0(3);
        cycle();
        if0.acc_clr = 1'b0; if0.in_valid = 1'b0;
        n_checks++; if (if0.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL clr_in_out: out_valid=%b want 0", if0.out_valid); end
        repeat (4) feed0(2);
        n_checks++; if (if0.out_valid !== 1'b1 || if0.res !== 48'd8) begin
            n_fail++; $display("FAIL clr_after_out: res=%0h ov=%b, want 8/1", if0.res, if0.out_valid); end
        cycle();
    endtask

    task automatic test_random();
        longint q[$];
        longint er, p;
        logic [63:0] r;
        bit eo;
        int k, hold;
        for (int g = 0; g < 6; g++) begin
            q = {};
            for (int j = 0; j < 4; j++) begin
                r = {$urandom(), $urandom()};
                p = longint'({{22{r[41]}}, r[41:0]});
                q.push_back(p);
            end
            model_group(q, 48, SAT, er, eo);
            k = 0;
            while (k < 4) begin
                if ($urandom_range(0, 3) == 0) begin
                    if0.in_valid = 1'b0;
                    cycle();
                end else begin
                    feed0(q[k]);
                    k++;
                end
            end
            n_checks++; if (if0.out_valid !== 1'b1 || if0.res !== er[47:0] || if0.ovf !== eo) begin
                n_fail++; $display("FAIL rand_res: grp %0d res=%0h ov=%b ovf=%b, want %0h/1/%b", g, if0.res, if0.out_valid, if0.ovf, er[47:0], eo); end
            hold = $urandom_range(1, 3);
            if0.out_ready = 1'b0; if0.in_valid = 1'b1; drive0(longint'($urandom_range(1, 1000)));
            repeat (hold) cycle();
            n_checks++; if (if0.out_valid !== 1'b1 || if0.res !== er[47:0]) begin
                n_fail++; $display("FAIL rand_hold: grp %0d res=%0h ov=%b, want %0h/1", g, if0.res, if0.out_valid, er[47:0]); end
            if0.out_ready = 1'b1; if0.in_valid = 1'b0;
            cycle();
            n_checks++; if (if0.out_valid !== 1'b0) begin
                n_fail++; $display("FAIL rand_release: grp %0d out_valid=%b want 0", g, if0.out_valid); end
        end
    endtask

    task automatic test_overflow();
        longint q[$];
        longint er, big;
        bit eo;
        big = (longint'(1) <<< 41) - 1;
        q = {big, big, big, big};
        model_group(q, 48, SAT, er, eo);
        foreach (q[i]) feed0(q[i]);
        n_checks++; if (if0.res !== er[47:0] || if0.ovf !== 1'b0 || if0.out_valid !== 1'b1) begin
            n_fail++; $display("FAIL ovf_48: res=%0h ovf=%b ov=%b, want %0h/0/1", if0.res, if0.ovf, if0.out_valid, er[47:0]); end
        cycle();
        model_group(q, 43, SAT, er, eo);
        foreach (q[i]) feed1(q[i]);
        n_checks++; if (if1.res !== er[42:0] || if1.ovf !== eo || if1.out_valid !== 1'b1) begin
            n_fail++; $display("FAIL ovf_43_pos: res=%0h ovf=%b ov=%b, want %0h/%b/1", if1.res, if1.ovf, if1.out_valid, er[42:0], eo); end
        cycle();
        q = {-(longint'(1) <<< 41), -(longint'(1) <<< 41), -(longint'(1) <<< 41), -(longint'(1) <<< 41)};
        model_group(q, 43, SAT, er, eo);
        foreach (q[i]) feed1(q[i]);
        n_checks++; if (if1.res !== er[42:0] || if1.ovf !== eo || if1.out_valid !== 1'b1) begin
            n_fail++; $display("FAIL ovf_43_neg: res=%0h ovf=%b ov=%b, want %0h/%b/1", if1.res, if1.ovf, if1.out_valid, er[42:0], eo); end
        cycle();
        q = {1, 1, 1, 1};
        model_group(q, 43, SAT, er, eo);
        foreach (q[i]) feed1(q[i]);
        n_checks++; if (if1.res !== er[42:0] || if1.ovf !== eo) begin
            n_fail++; $display("FAIL ovf_clears: res=%0h ovf=%b, want %0h/%b", if1.res, if1.ovf, er[42:0], eo); end
        cycle();
    endtask

    task automatic test_back_to_back();
        logic [47:0] want;
        for (int k = 1; k <= 8; k++) begin
            if2.prod_hi = '0; if2.prod_lo = 4'(k);
            if (k >= 8) begin if2.prod_hi = 38'(k >> 4); end
            if2.in_valid = 1'b1; if2.out_ready = 1'b1;
            #1;
            n_checks++; if (if2.in_ready !== 1'b1) begin
                n_fail++; $display("FAIL b2b_ready: k=%0d got %b want 1", k, if2.in_ready); end
            cycle();
            want = 48'(k);
            n_checks++; if (if2.out_valid !== 1'b1 || if2.res !== want) begin
                n_fail++; $display("FAIL b2b_res: k=%0d res=%0h ov=%b, want %0h/1", k, if2.res, if2.out_valid, want); end
        end
        if2.in_valid = 1'b0;
        cycle();
        n_checks++; if (if2.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL b2b_drain: out_valid=%b want 0", if2.out_valid); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        idle_all();
        test_reset();
        test_basic();
        test_negative();
        test_backpressure();
        test_clr();
        test_random();
        test_overflow();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
